// File: rtl/computer_pkg.sv
// ---------------------------------------------------------------------------
// computer_pkg
//   Shared constants for the 65C02 computer: main RAM geometry, the CPU
//   address map, and the state encoding of the RAM arbiter FSM.
//   No ports; imported by the arbiter and by anything decoding the map.
// ---------------------------------------------------------------------------
package computer_pkg;

    // Main RAM (spram32k8) geometry
    localparam int RAM_AW = 15;
    localparam int RAM_DW = 8;

    // CPU address map (16-bit CPU bus)
    localparam logic [15:0] RAM_BASE = 16'h0000;
    localparam logic [15:0] RAM_LAST = 16'h7FFF;
    localparam logic [15:0] IO_BASE  = 16'h8400;
    localparam logic [15:0] VDP_BASE = 16'hF7FC;
    localparam logic [15:0] VDP_LAST = 16'hF7FF;
    localparam logic [15:0] ROM_BASE = 16'hF800;
    localparam logic [15:0] ROM_LAST = 16'hFFFF;

    // RAM arbiter FSM: IDLE may issue a DMA access, ACK completes it
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_ACK  = 1'b1
    } arb_state_e;

    // RAM occupies the lower half of the CPU space
    function automatic logic is_ram_addr(input logic [15:0] addr);
        return (addr[15] == 1'b0);
    endfunction

endpackage

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//   Shares the single-port 32Kx8 main RAM between the 65C02 and one DMA
//   master on the memory clock. The CPU owns the RAM whenever its bus window
//   is active and it decodes to RAM; a pending DMA access is issued in any
//   cycle the CPU does not own the RAM, and acknowledged exactly one cycle
//   later when the registered RAM output is available.
//
//   clk, reset          memory clock, synchronous active-high reset
//   cpu_slot/cpu_sel    CPU bus window active / CPU address hits RAM
//   cpu_we/addr/wdata   CPU access; cpu_rdata is the registered read result
//   dma_req/we/addr/... DMA access, level request held until dma_ack
//   dma_ack/dma_rdata   one-cycle completion pulse and read data (held)
//   ram_*               to/from the synchronous RAM (1-cycle read latency)
// ---------------------------------------------------------------------------
module ram_arbiter
    import computer_pkg::*;
#(
    parameter int AW = RAM_AW,
    parameter int DW = RAM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_slot,
    input  logic          cpu_sel,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    arb_state_e    state_q, state_d;
    logic          dma_rd_q, dma_rd_d;        // issued DMA access was a read
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;
    logic          cpu_rd_q, cpu_rd_d;        // previous cycle was a CPU read
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic          cpu_own;

    assign cpu_own = cpu_slot & cpu_sel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            dma_rd_q    <= 1'b0;
            dma_rdata_q <= '0;
            cpu_rd_q    <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            dma_rd_q    <= dma_rd_d;
            dma_rdata_q <= dma_rdata_d;
            cpu_rd_q    <= cpu_rd_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        dma_rd_d    = dma_rd_q;
        dma_rdata_d = dma_rdata_q;
        dma_ack     = 1'b0;
        // With no owner the RAM port idles on the CPU bus with writes off
        ram_addr    = cpu_addr;
        ram_wdata   = cpu_wdata;
        ram_we      = 1'b0;

        if (cpu_own) begin
            ram_we = cpu_we;
        end

        case (state_q)
            ARB_IDLE: begin
                if (dma_req && !cpu_own) begin
                    ram_addr  = dma_addr;
                    ram_wdata = dma_wdata;
                    ram_we    = dma_we;
                    dma_rd_d  = ~dma_we;
                    state_d   = ARB_ACK;
                end
            end
            ARB_ACK: begin
                // RAM output already holds the issued read, so the CPU may
                // use the port this cycle without disturbing the capture.
                dma_ack = 1'b1;
                if (dma_rd_q) begin
                    dma_rdata_d = ram_rdata;
                end
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase

        // An access in flight during reset is dropped: no write, no ack
        if (reset) begin
            ram_we  = 1'b0;
            dma_ack = 1'b0;
        end
    end

    assign cpu_rd_d    = cpu_own & ~cpu_we;
    assign cpu_rdata_d = cpu_rd_q ? ram_rdata : cpu_rdata_q;

    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

    localparam int AW = 15;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_slot, cpu_sel, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          dma_req, dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    int checks_total  = 0;
    int checks_passed = 0;

    always #5 clk = ~clk;

    ram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .cpu_slot (cpu_slot),
        .cpu_sel  (cpu_sel),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .dma_req  (dma_req),
        .dma_we   (dma_we),
        .dma_addr (dma_addr),
        .dma_wdata(dma_wdata),
        .dma_ack  (dma_ack),
        .dma_rdata(dma_rdata),
        .ram_addr (ram_addr),
        .ram_we   (ram_we),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Behavioural spram32k8: read-first, registered output
    logic [DW-1:0] mem [0:(1<<AW)-1];

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h3C;
    endfunction

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = pat(AW'(i));
    end

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Protocol monitor: an ack follows every issue cycle and nothing else
    logic issue_prev = 1'b0;
    always @(posedge clk)
        issue_prev <= !reset && dma_req && !(cpu_slot && cpu_sel) && !dma_ack;

    always @(negedge clk) begin
        if (reset) chk("mon_we_in_reset", ram_we, 1'b0);
        else       chk("mon_ack_after_issue", dma_ack, issue_prev);
    end

    task automatic drive(input logic slot, input logic sel, input logic cwe,
                         input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                         input logic req, input logic dwe,
                         input logic [AW-1:0] daddr, input logic [DW-1:0] dwd);
        cpu_slot = slot; cpu_sel = sel; cpu_we = cwe; cpu_addr = caddr; cpu_wdata = cwd;
        dma_req = req; dma_we = dwe; dma_addr = daddr; dma_wdata = dwd;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          slot, sel, cwe;
        logic [AW-1:0] caddr;
        logic [DW-1:0] cwd;
        logic          req, dwe;
        logic [AW-1:0] daddr;
        logic [DW-1:0] dwd;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          e_ack;
        logic [DW-1:0] e_crd, e_drd;
    } vec_t;

    vec_t vt [11];

    initial begin
        int acks;
        int k;

        //        slot  sel  cwe  caddr     cwd    req  dwe  daddr     dwd    e_we e_addr    e_wd   ack  crd    drd
        vt[0]  = '{1'b1,1'b1,1'b1,15'h0123,8'hA5, 1'b0,1'b0,15'h0000,8'h00, 1'b1,15'h0123,8'hA5,1'b0,8'h00,8'h00};
        vt[1]  = '{1'b1,1'b1,1'b0,15'h0123,8'h00, 1'b0,1'b0,15'h0000,8'h00, 1'b0,15'h0123,8'h00,1'b0,8'h00,8'h00};
        vt[2]  = '{1'b0,1'b0,1'b0,15'h0123,8'h00, 1'b0,1'b0,15'h0000,8'h00, 1'b0,15'h0123,8'h00,1'b0,8'hA5,8'h00};
        vt[3]  = '{1'b0,1'b0,1'b0,15'h0123,8'h00, 1'b1,1'b1,15'h7FFF,8'h5A, 1'b1,15'h7FFF,8'h5A,1'b0,8'hA5,8'h00};
        vt[4]  = '{1'b0,1'b0,1'b0,15'h0123,8'h00, 1'b0,1'b0,15'h0000,8'h00, 1'b0,15'h0123,8'h00,1'b1,8'hA5,8'h00};
        vt[5]  = '{1'b0,1'b0,1'b0,15'h0123,8'h00, 1'b1,1'b0,15'h7FFF,8'h00, 1'b0,15'h7FFF,8'h00,1'b0,8'hA5,8'h00};
        vt[6]  = '{1'b0,1'b0,1'b0,15'h0123,8'h00, 1'b0,1'b0,15'h0000,8'h00, 1'b0,15'h0123,8'h00,1'b1,8'hA5,8'h5A};
        vt[7]  = '{1'b0,1'b0,1'b0,15'h0123,8'h00, 1'b0,1'b0,15'h0000,8'h00, 1'b0,15'h0123,8'h00,1'b0,8'hA5,8'h5A};
        vt[8]  = '{1'b1,1'b1,1'b0,15'h0040,8'h00, 1'b1,1'b1,15'h0400,8'hEE, 1'b0,15'h0040,8'h00,1'b0,8'hA5,8'h5A};
        vt[9]  = '{1'b0,1'b0,1'b0,15'h0040,8'h00, 1'b0,1'b0,15'h0000,8'h00, 1'b0,15'h0040,8'h00,1'b0,8'h7C,8'h5A};
        vt[10] = '{1'b0,1'b0,1'b0,15'h0040,8'h00, 1'b0,1'b0,15'h0000,8'h00, 1'b0,15'h0040,8'h00,1'b0,8'h7C,8'h5A};

        // Reset state
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        edge_step();
        edge_step();
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_dma_ack", dma_ack, 1'b0);
        chk("rst_dma_rdata", dma_rdata, 8'h00);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        reset = 1'b0;

        // Table: CPU write/read, DMA write/read at 0x7FFF, request withdrawn before issue
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].slot, vt[i].sel, vt[i].cwe, vt[i].caddr, vt[i].cwd,
                  vt[i].req, vt[i].dwe, vt[i].daddr, vt[i].dwd);
            #1;
            chk($sformatf("v%0d_ram_we", i), ram_we, vt[i].e_we);
            chk($sformatf("v%0d_ram_addr", i), ram_addr, vt[i].e_addr);
            chk($sformatf("v%0d_ram_wdata", i), ram_wdata, vt[i].e_wd);
            chk($sformatf("v%0d_dma_ack", i), dma_ack, vt[i].e_ack);
            edge_step();
            chk($sformatf("v%0d_cpu_rdata", i), cpu_rdata, vt[i].e_crd);
            chk($sformatf("v%0d_dma_rdata", i), dma_rdata, vt[i].e_drd);
            $display("vec %0d: ram_we=%0b addr=%h ack=%0b cpu_rdata=%h dma_rdata=%h",
                     i, vt[i].e_we, vt[i].e_addr, vt[i].e_ack, cpu_rdata, dma_rdata);
        end
        chk("withdrawn_req_no_write", mem[15'h0400], pat(15'h0400));

        // Contention: CPU writes for 8 cycles while DMA read of 0x0123 waits
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 1'b1, AW'(15'h0200 + i), DW'(8'h10 + i), 1'b1, 1'b0, 15'h0123, 8'h00);
            #1;
            chk($sformatf("cont%0d_ram_addr", i), ram_addr, 15'h0200 + i);
            chk($sformatf("cont%0d_ram_we", i), ram_we, 1'b1);
            chk($sformatf("cont%0d_ack", i), dma_ack, 1'b0);
            edge_step();
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 15'h0123, 8'h00);
        #1;
        chk("cont_issue_addr", ram_addr, 15'h0123);
        chk("cont_issue_we", ram_we, 1'b0);
        edge_step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("cont_ack", dma_ack, 1'b1);
        edge_step();
        chk("cont_rdata", dma_rdata, 8'hA5);
        $display("contention: dma read 0x0123 -> %h", dma_rdata);

        // CPU window with cpu_sel=0: DMA served at once; CPU takes RAM in the ACK cycle
        drive(1'b1, 1'b0, 1'b1, 15'h0300, 8'h77, 1'b1, 1'b0, 15'h0010, 8'h00);
        #1;
        chk("win_issue_addr", ram_addr, 15'h0010);
        chk("win_issue_we", ram_we, 1'b0);
        edge_step();
        drive(1'b1, 1'b1, 1'b1, 15'h0300, 8'h77, 1'b0, 1'b0, '0, '0);
        #1;
        chk("win_ack", dma_ack, 1'b1);
        chk("win_cpu_we", ram_we, 1'b1);
        chk("win_cpu_addr", ram_addr, 15'h0300);
        edge_step();
        chk("win_rdata", dma_rdata, pat(15'h0010));
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        edge_step();
        chk("win_cpu_write_mem", mem[15'h0300], 8'h77);
        $display("window: dma read 0x0010 -> %h", dma_rdata);

        // Back-to-back: req held 10 cycles, reading the contention writes
        acks = 0;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(15'h0200 + k), 8'h00);
            #1;
            chk($sformatf("b2b%0d_ack", c), dma_ack, (c % 2) == 1);
            if ((c % 2) == 0) chk($sformatf("b2b%0d_addr", c), ram_addr, 15'h0200 + k);
            if (dma_ack) acks++;
            edge_step();
            if ((c % 2) == 1) begin
                chk($sformatf("b2b%0d_rdata", c), dma_rdata, 8'h10 + k);
                $display("b2b: read %h -> %h", 15'h0200 + k, dma_rdata);
                k++;
            end
        end
        chk("b2b_ack_count", acks, 5);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        edge_step();

        // Reset in the issue cycle drops the write
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 15'h0500, 8'h99);
        #1;
        chk("rmid_ram_we", ram_we, 1'b0);
        chk("rmid_ack", dma_ack, 1'b0);
        edge_step();
        chk("rmid_ack_after", dma_ack, 1'b0);
        chk("rmid_dma_rdata", dma_rdata, 8'h00);
        chk("rmid_cpu_rdata", cpu_rdata, 8'h00);
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        edge_step();
        reset = 1'b0;
        edge_step();
        chk("rmid_no_write", mem[15'h0500], pat(15'h0500));
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 15'h0500, 8'h00);
        #1;
        chk("rpost_issue_addr", ram_addr, 15'h0500);
        edge_step();
        drive(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
        #1;
        chk("rpost_ack", dma_ack, 1'b1);
        edge_step();
        chk("rpost_rdata", dma_rdata, pat(15'h0500));
        $display("post-reset: dma read 0x0500 -> %h", dma_rdata);
        edge_step();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
